// File: rtl/sequenciador_pc_pkg.sv
// Shared definitions for the program-counter sequencer: op codes and
// the switch-entry wait FSM encoding, used by the RTL and the bench.
package sequenciador_pc_pkg;

  localparam int OP_W = 4;

  // Op codes issued by the control unit; 9..15 behave as OP_NEXT.
  typedef enum logic [OP_W-1:0] {
    OP_NEXT     = 4'd0,
    OP_JMP_IMM  = 4'd1,
    OP_JMP_REG  = 4'd2,
    OP_BR_IMM   = 4'd3,
    OP_BR_REG   = 4'd4,
    OP_CALL     = 4'd5,
    OP_RET      = 4'd6,
    OP_WAIT_IN  = 4'd7,
    OP_WAIT_DLY = 4'd8
  } op_e;

  // Switch-entry handshake: wait for press, wait for release, latch.
  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_PRESS = 2'd1,
    W_DONE  = 2'd2
  } wait_state_e;

endpackage

// File: rtl/sequenciador_pc_if.sv
// Bus between the control unit / register bank and the PC sequencer.
// master = control unit side, slave = sequencer.
interface sequenciador_pc_if
  import sequenciador_pc_pkg::*;
#(
  parameter int AW   = 8,
  parameter int SW_W = 16,
  parameter int SPW  = 5
);
  logic            en;
  logic [OP_W-1:0] op;
  logic            cond;
  logic [AW-1:0]   imm_addr;
  logic [AW-1:0]   reg_addr;
  logic            ent;
  logic [SW_W-1:0] sw_in;
  logic            dly_busy;
  logic            clr_err;
  logic [AW-1:0]   pc;
  logic [SW_W-1:0] sw_reg;
  logic            in_done;
  logic            stall;
  logic [SPW-1:0]  sp;
  logic            ovf;
  logic            unf;

  modport master (
    output en, op, cond, imm_addr, reg_addr, ent, sw_in, dly_busy, clr_err,
    input  pc, sw_reg, in_done, stall, sp, ovf, unf
  );

  modport slave (
    input  en, op, cond, imm_addr, reg_addr, ent, sw_in, dly_busy, clr_err,
    output pc, sw_reg, in_done, stall, sp, ovf, unf
  );
endinterface

// File: rtl/sequenciador_pc_pilha_retorno.sv
// Return-address LIFO: registered storage, combinational top-of-stack.
// Push when full and pop when empty are ignored; the caller flags them.
module pilha_retorno #(
  parameter  int AW    = 8,
  parameter  int DEPTH = 16,
  localparam int SPW   = $clog2(DEPTH + 1),
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [AW-1:0]  data,
  output logic [AW-1:0]  top,
  output logic [SPW-1:0] sp,
  output logic           full,
  output logic           empty
);
  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp_reg;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  rd_idx;

  assign full   = (sp_reg == SPW'(DEPTH));
  assign empty  = (sp_reg == '0);
  assign wr_idx = sp_reg[IW-1:0];
  assign rd_idx = IW'(sp_reg - SPW'(1));
  assign top    = empty ? '0 : mem[rd_idx];
  assign sp     = sp_reg;

  // Occupancy counter, saturating at 0 and DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_reg <= '0;
    end else if (push && !full) begin
      sp_reg <= sp_reg + SPW'(1);
    end else if (pop && !empty) begin
      sp_reg <= sp_reg - SPW'(1);
    end
  end

  // Entry storage; contents are meaningless after reset since sp is 0.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= data;
    end
  end
endmodule

// File: rtl/sequenciador_pc.sv
// Program-counter sequencer: next-PC selection, call/return stack with
// sticky overflow/underflow flags, switch-entry wait with a synchronised
// active-low button, and a delay-counter wait.
module sequenciador_pc
  import sequenciador_pc_pkg::*;
#(
  parameter int            AW       = 8,
  parameter int            DEPTH    = 16,
  parameter int            SW_W     = 16,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            SYNC     = 2
) (
  input logic               clk,
  input logic               reset,
  sequenciador_pc_if.slave  bus
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic [AW-1:0]   pc_reg, pc_next, pc_inc;
  logic [SW_W-1:0] sw_reg_reg, sw_reg_next;
  logic            in_done_reg, in_done_next;
  logic            ovf_reg, ovf_next;
  logic            unf_reg, unf_next;
  logic            dly_arm_reg, dly_arm_next;
  wait_state_e     wst_reg, wst_next;
  logic [SYNC-1:0] sync_reg;
  logic            ent_s;
  logic            push, pop, full, empty, stall_c;
  logic [AW-1:0]   top;
  logic [SPW-1:0]  sp;

  pilha_retorno #(.AW(AW), .DEPTH(DEPTH)) u_pilha (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data(pc_inc),
    .top(top), .sp(sp), .full(full), .empty(empty)
  );

  assign pc_inc      = pc_reg + AW'(1);
  assign ent_s       = sync_reg[SYNC-1];
  assign bus.pc      = pc_reg;
  assign bus.sw_reg  = sw_reg_reg;
  assign bus.in_done = in_done_reg;
  assign bus.stall   = stall_c;
  assign bus.sp      = sp;
  assign bus.ovf     = ovf_reg;
  assign bus.unf     = unf_reg;

  // Button synchroniser; free-running so en never stalls metastability
  // settling. Resets to 1 (released) so no phantom press after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_reg <= '1;
    else        sync_reg <= {sync_reg[SYNC-2:0], bus.ent};
  end

  // State register for PC, wait FSM, delay arm, switch latch and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg      <= RESET_PC;
      sw_reg_reg  <= '0;
      in_done_reg <= 1'b0;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
      dly_arm_reg <= 1'b0;
      wst_reg     <= W_IDLE;
    end else begin
      pc_reg      <= pc_next;
      sw_reg_reg  <= sw_reg_next;
      in_done_reg <= in_done_next;
      ovf_reg     <= ovf_next;
      unf_reg     <= unf_next;
      dly_arm_reg <= dly_arm_next;
      wst_reg     <= wst_next;
    end
  end

  // Next-state decode per op; any op other than the active wait abandons it.
  always_comb begin
    pc_next      = pc_reg;
    sw_reg_next  = sw_reg_reg;
    in_done_next = 1'b0;
    ovf_next     = ovf_reg;
    unf_next     = unf_reg;
    dly_arm_next = dly_arm_reg;
    wst_next     = wst_reg;
    push         = 1'b0;
    pop          = 1'b0;
    stall_c      = 1'b0;
    if (bus.en) begin
      if (bus.clr_err) begin
        ovf_next = 1'b0;
        unf_next = 1'b0;
      end
      wst_next     = W_IDLE;
      dly_arm_next = 1'b0;
      case (bus.op)
        OP_JMP_IMM: pc_next = bus.imm_addr;
        OP_JMP_REG: pc_next = bus.reg_addr;
        OP_BR_IMM:  pc_next = bus.cond ? bus.imm_addr : pc_inc;
        OP_BR_REG:  pc_next = bus.cond ? bus.reg_addr : pc_inc;
        OP_CALL: begin
          pc_next = bus.imm_addr;
          if (full) ovf_next = 1'b1;
          else      push     = 1'b1;
        end
        OP_RET: begin
          if (empty) begin
            unf_next = 1'b1;
            pc_next  = pc_inc;
          end else begin
            pop     = 1'b1;
            pc_next = top;
          end
        end
        OP_WAIT_IN: begin
          case (wst_reg)
            W_IDLE: begin
              stall_c = 1'b1;
              if (!ent_s) wst_next = W_PRESS;
            end
            W_PRESS: begin
              stall_c  = 1'b1;
              wst_next = ent_s ? W_DONE : W_PRESS;
            end
            default: begin
              sw_reg_next  = bus.sw_in;
              pc_next      = pc_inc;
              in_done_next = 1'b1;
            end
          endcase
        end
        OP_WAIT_DLY: begin
          // The first cycle only arms, so a stale busy=0 cannot skip the wait.
          if (dly_arm_reg && !bus.dly_busy) begin
            pc_next = pc_inc;
          end else begin
            dly_arm_next = 1'b1;
            stall_c      = 1'b1;
          end
        end
        default: pc_next = pc_inc;
      endcase
    end
  end
endmodule

// File: tb/tb_sequenciador_pc.sv
// Scoreboard bench for sequenciador_pc: the driver runs a behavioural
// model and queues expected results; monitors compare as the DUT responds.
module tb_sequenciador_pc;
  localparam int AW = 8, DEPTH = 16, SW_W = 16, SPW = 5, SYNC = 2;

  typedef struct packed {
    logic [AW-1:0]   pc;
    logic [SPW-1:0]  sp;
    logic            ovf;
    logic            unf;
    logic            in_done;
    logic [SW_W-1:0] sw;
  } exp_t;

  logic clk;
  logic reset;
  sequenciador_pc_if #(.AW(AW), .SW_W(SW_W), .SPW(SPW)) bus ();

  sequenciador_pc #(.AW(AW), .DEPTH(DEPTH), .SW_W(SW_W), .RESET_PC(8'h00), .SYNC(SYNC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int txn      = 0;
  int rel_edge = 0;
  int in_done_edge = -1;
  exp_t exp_q[$];
  bit   stall_q[$];

  // Stimulus held between steps
  logic            d_en, d_cond, d_ent, d_busy, d_clr;
  logic [3:0]      d_op;
  logic [AW-1:0]   d_imm, d_reg;
  logic [SW_W-1:0] d_sw;
  bit              d_mark;

  // Reference model state
  int  m_pc;
  int  m_stk[$];
  bit  m_ovf, m_unf, m_in_done, m_done;
  logic [SW_W-1:0] m_sw;
  bit  m_saw_press, m_rel_seen;
  int  m_dly;
  bit  m_entq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0; m_in_done = 0; m_done = 0;
    m_sw = '0; m_saw_press = 0; m_rel_seen = 0; m_dly = 0;
    m_entq.delete();
    for (int i = 0; i < SYNC; i++) m_entq.push_back(1'b1);
  endtask

  // One enabled-or-held clock cycle of the specified behaviour.
  task automatic model_step(output bit st);
    bit ent_s;
    int nxt;
    ent_s = m_entq[0];
    nxt = (m_pc + 1) % 256;
    st = 0; m_in_done = 0; m_done = 0;
    if (d_en) begin
      if (d_clr) begin m_ovf = 0; m_unf = 0; end
      if (d_op != 4'd7) begin m_saw_press = 0; m_rel_seen = 0; end
      if (d_op != 4'd8) m_dly = 0;
      case (d_op)
        4'd1: m_pc = int'(d_imm);
        4'd2: m_pc = int'(d_reg);
        4'd3: m_pc = d_cond ? int'(d_imm) : nxt;
        4'd4: m_pc = d_cond ? int'(d_reg) : nxt;
        4'd5: begin
          if (m_stk.size() == DEPTH) m_ovf = 1; else m_stk.push_back(nxt);
          m_pc = int'(d_imm);
        end
        4'd6: begin
          if (m_stk.size() == 0) begin m_unf = 1; m_pc = nxt; end
          else m_pc = m_stk.pop_back();
        end
        4'd7: begin
          if (m_rel_seen) begin
            m_sw = d_sw; m_pc = nxt; m_in_done = 1; m_done = 1;
            m_saw_press = 0; m_rel_seen = 0;
          end else begin
            st = 1;
            if (!m_saw_press) m_saw_press = !ent_s;
            else if (ent_s) m_rel_seen = 1;
          end
        end
        4'd8: begin
          if (m_dly > 0 && !d_busy) begin m_pc = nxt; m_dly = 0; end
          else begin st = 1; m_dly++; end
        end
        default: m_pc = nxt;
      endcase
    end
    void'(m_entq.pop_front());
    m_entq.push_back(d_ent);
  endtask

  // Called at a negedge: drive inputs, queue expectations, wait a cycle.
  task automatic step();
    exp_t e;
    bit st;
    bus.en = d_en; bus.op = d_op; bus.cond = d_cond; bus.imm_addr = d_imm;
    bus.reg_addr = d_reg; bus.ent = d_ent; bus.sw_in = d_sw;
    bus.dly_busy = d_busy; bus.clr_err = d_clr;
    if (d_mark) begin rel_edge = edge_cnt + 1; d_mark = 0; end
    model_step(st);
    e.pc = AW'(m_pc); e.sp = SPW'(m_stk.size()); e.ovf = m_ovf; e.unf = m_unf;
    e.in_done = m_in_done; e.sw = m_sw;
    exp_q.push_back(e);
    stall_q.push_back(st);
    @(negedge clk);
  endtask

  // Called at a negedge: assert reset, check cleared state, release.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_sw_reg", 32'(bus.sw_reg), 32'h0);
    check("rst_in_done", 32'(bus.in_done), 32'h0);
    check("rst_sp", 32'(bus.sp), 32'h0);
    check("rst_ovf", 32'(bus.ovf), 32'h0);
    check("rst_unf", 32'(bus.unf), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic defaults();
    d_en = 1; d_op = 4'd0; d_cond = 0; d_imm = '0; d_reg = '0; d_ent = 1;
    d_sw = '0; d_busy = 0; d_clr = 0; d_mark = 0;
  endtask

  // Stall monitor: combinational stall sampled mid low phase.
  initial begin
    bit st;
    forever begin
      @(negedge clk); #2;
      if (stall_q.size() > 0) begin
        st = stall_q.pop_front();
        check("stall", 32'(bus.stall), 32'(st));
      end
    end
  end

  // State monitor: registered outputs sampled just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      edge_cnt++;
      if (bus.in_done === 1'b1 && in_done_edge < 0) in_done_edge = edge_cnt;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: pc=%02h sp=%0d ovf=%b unf=%b in_done=%b sw_reg=%04h", txn,
                 bus.pc, bus.sp, bus.ovf, bus.unf, bus.in_done, bus.sw_reg);
        check("pc", 32'(bus.pc), 32'(e.pc));
        check("sp", 32'(bus.sp), 32'(e.sp));
        check("ovf", 32'(bus.ovf), 32'(e.ovf));
        check("unf", 32'(bus.unf), 32'(e.unf));
        check("in_done", 32'(bus.in_done), 32'(e.in_done));
        check("sw_reg", 32'(bus.sw_reg), 32'(e.sw));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    defaults();
    reset = 1'b0;
    bus.en = 0; bus.op = '0; bus.cond = 0; bus.imm_addr = '0; bus.reg_addr = '0;
    bus.ent = 1; bus.sw_in = '0; bus.dly_busy = 0; bus.clr_err = 0;
    @(negedge clk);
    do_reset();

    // Sequential count and wrap
    repeat (5) step();
    d_op = 4'd1; d_imm = 8'hFF; step();
    d_op = 4'd0; step();

    // Branches and register jump
    d_op = 4'd1; d_imm = 8'd3; step();
    d_op = 4'd3; d_cond = 0; d_imm = 8'd99; step();
    d_cond = 1; d_imm = 8'd20; step();
    d_op = 4'd2; d_reg = 8'd40; step();
    d_op = 4'd4; d_cond = 0; d_reg = 8'd77; step();
    d_cond = 1; step();

    // Nested calls, returns, underflow, clear
    d_op = 4'd1; d_imm = 8'd1; step();
    d_op = 4'd5; d_imm = 8'd10; step();
    d_imm = 8'd30; step();
    d_op = 4'd6; repeat (3) step();
    d_op = 4'd0; d_clr = 1; step(); d_clr = 0;

    // Fill the stack, overflow, drain, clear
    for (int i = 0; i < DEPTH; i++) begin
      d_op = 4'd5; d_imm = 8'(40 + i * 3); step();
    end
    d_imm = 8'hAA; step();
    d_op = 4'd6; repeat (DEPTH) step();
    d_op = 4'd0; d_clr = 1; step(); d_clr = 0;

    // Pushed return address wraps
    d_op = 4'd1; d_imm = 8'hFF; step();
    d_op = 4'd5; d_imm = 8'd5; step();
    d_op = 4'd6; step();

    // Switch entry: idle, press 3 cycles, release, check latency
    d_op = 4'd7; d_sw = 16'hBEEF; d_ent = 1; repeat (4) step();
    d_ent = 0; repeat (3) step();
    d_ent = 1; d_mark = 1; in_done_edge = -1;
    for (int k = 0; k < 20 && !m_done; k++) step();
    d_op = 4'd0; step(); step();
    check("in_done_latency", 32'(in_done_edge), 32'(rel_edge + SYNC + 1));

    // Press already held before the wait begins
    d_sw = 16'h1234; d_ent = 0; repeat (3) step();
    d_op = 4'd7; repeat (4) step();
    d_ent = 1;
    for (int k = 0; k < 20 && !m_done; k++) step();
    d_op = 4'd0; step();

    // Reset while the press is held
    d_op = 4'd7; d_ent = 0; repeat (4) step();
    do_reset();
    d_ent = 1; repeat (3) step();
    d_op = 4'd0; step();

    // Delay wait variants
    d_op = 4'd8; d_busy = 0; repeat (2) step();
    d_op = 4'd0; step();
    d_op = 4'd8; d_busy = 1; repeat (5) step();
    d_busy = 0; step();
    d_op = 4'd0; step();
    d_op = 4'd8; d_busy = 1; repeat (2) step();
    d_en = 0; d_busy = 0; repeat (3) step();
    d_en = 1; step();
    d_op = 4'd0; step();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      d_en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 0) d_op = 4'($urandom_range(0, 15));
      d_cond = 1'($urandom_range(0, 1));
      d_imm  = 8'($urandom_range(0, 255));
      d_reg  = 8'($urandom_range(0, 255));
      d_sw   = 16'($urandom_range(0, 65535));
      d_busy = 1'($urandom_range(0, 1));
      d_clr  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) d_ent = ~d_ent;
      step();
    end
    defaults();
    step();

    check("queues_drained", 32'(exp_q.size() + stall_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
